// File: rtl/hasher_arbiter.sv
// rtl/hasher_arbiter.sv - shares one hasher between two requesters, one whole message per grant
module hasher_arbiter #(
  parameter int HASH_TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic [1:0]              reqValidIn,
  input  logic [1:0]              reqFirstIn,
  input  logic [1:0]              reqLastIn,
  input  logic [1:0][15:0][31:0]  reqBlockIn,
  output logic [1:0]              reqReadyOut,
  output logic [1:0]              respValidOut,
  output logic [1:0]              respErrOut,
  output logic [7:0][31:0]        respHashOut,
  output logic                    hValidOut,
  output logic                    hFirstOut,
  output logic                    hLastOut,
  output logic [15:0][31:0]       hBlockOut,
  input  logic                    hReadyIn,
  input  logic                    hValidIn,
  input  logic [7:0][31:0]        hHashIn
);

  localparam int CW = $clog2(HASH_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(HASH_TIMEOUT);

  typedef enum logic [1:0] {IDLE, FORWARD, WAIT_HASH, DELIVER} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_grant;
  logic             r_last_grant;
  logic [CW-1:0]    r_cnt;
  logic [7:0][31:0] r_hash;

  logic [1:0] w_elig;
  logic       w_any_elig;
  logic       w_win;
  logic       w_beat;
  logic       w_timeout;
  logic [1:0] w_gmask;

  // Round-robin: on a tie the requester not served last wins.
  assign w_elig     = reqValidIn & reqFirstIn;
  assign w_any_elig = |w_elig;
  assign w_win      = (&w_elig) ? ~r_last_grant : w_elig[1];
  assign w_gmask    = r_grant ? 2'b10 : 2'b01;
  assign w_beat     = (r_state == FORWARD) && reqValidIn[r_grant] && hReadyIn;
  assign w_timeout  = (r_state == WAIT_HASH) && !hValidIn && (r_cnt == TIMEOUT_VAL);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (w_any_elig) w_next = FORWARD;
      FORWARD:   if (w_beat && reqLastIn[r_grant]) w_next = WAIT_HASH;
      WAIT_HASH: begin
        if (hValidIn) begin
          w_next = DELIVER;
        end else if (w_timeout) begin
          w_next = IDLE;
        end
      end
      DELIVER:   w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // The counter idles at zero so it is already clear on entry to WAIT_HASH.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_hash       <= '0;
    end else begin
      if (r_state == IDLE && w_any_elig) begin
        r_grant <= w_win;
      end
      if (r_state == WAIT_HASH) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end
      if (r_state == WAIT_HASH && hValidIn) begin
        r_hash <= hHashIn;
      end
      if (r_state == DELIVER || w_timeout) begin
        r_last_grant <= r_grant;
      end
    end
  end

  always_comb begin
    reqReadyOut  = 2'b00;
    respValidOut = 2'b00;
    respErrOut   = 2'b00;
    respHashOut  = r_hash;
    hValidOut    = 1'b0;
    hFirstOut    = 1'b0;
    hLastOut     = 1'b0;
    hBlockOut    = '0;
    unique case (r_state)
      FORWARD: begin
        hValidOut   = reqValidIn[r_grant];
        hFirstOut   = reqFirstIn[r_grant];
        hLastOut    = reqLastIn[r_grant];
        hBlockOut   = reqBlockIn[r_grant];
        reqReadyOut = hReadyIn ? w_gmask : 2'b00;
      end
      WAIT_HASH: respErrOut   = w_timeout ? w_gmask : 2'b00;
      DELIVER:   respValidOut = w_gmask;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hasher_arbiter.sv
// tb/tb_hasher_arbiter.sv - directed and randomized checks of hasher_arbiter against a message-level model
module tb_hasher_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   resetN;
  logic [1:0]             reqValidIn, reqFirstIn, reqLastIn;
  logic [1:0][15:0][31:0] reqBlockIn;
  logic                   hReadyIn, hValidIn;
  logic [7:0][31:0]       hHashIn;

  logic [1:0]             reqReadyOut, respValidOut, respErrOut;
  logic [7:0][31:0]       respHashOut;
  logic                   hValidOut, hFirstOut, hLastOut;
  logic [15:0][31:0]      hBlockOut;

  logic [1:0]             t8_reqReadyOut, t8_respValidOut, t8_respErrOut;
  logic [7:0][31:0]       t8_respHashOut;
  logic                   t8_hValidOut, t8_hFirstOut, t8_hLastOut;
  logic [15:0][31:0]      t8_hBlockOut;

  int checks = 0;
  int failures = 0;

  hasher_arbiter u_dut (
    .clk(clk), .resetN(resetN),
    .reqValidIn(reqValidIn), .reqFirstIn(reqFirstIn), .reqLastIn(reqLastIn), .reqBlockIn(reqBlockIn),
    .reqReadyOut(reqReadyOut), .respValidOut(respValidOut), .respErrOut(respErrOut), .respHashOut(respHashOut),
    .hValidOut(hValidOut), .hFirstOut(hFirstOut), .hLastOut(hLastOut), .hBlockOut(hBlockOut),
    .hReadyIn(hReadyIn), .hValidIn(hValidIn), .hHashIn(hHashIn)
  );

  hasher_arbiter #(.HASH_TIMEOUT(8)) u_dut8 (
    .clk(clk), .resetN(resetN),
    .reqValidIn(reqValidIn), .reqFirstIn(reqFirstIn), .reqLastIn(reqLastIn), .reqBlockIn(reqBlockIn),
    .reqReadyOut(t8_reqReadyOut), .respValidOut(t8_respValidOut), .respErrOut(t8_respErrOut), .respHashOut(t8_respHashOut),
    .hValidOut(t8_hValidOut), .hFirstOut(t8_hFirstOut), .hLastOut(t8_hLastOut), .hBlockOut(t8_hBlockOut),
    .hReadyIn(hReadyIn), .hValidIn(hValidIn), .hHashIn(hHashIn)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic rand_block(output logic [15:0][31:0] b);
    for (int k = 0; k < 16; k++) b[k] = $urandom;
  endtask

  task automatic rand_hash(output logic [7:0][31:0] h);
    for (int k = 0; k < 8; k++) h[k] = $urandom;
  endtask

  task automatic do_reset();
    resetN = 1'b0; reqValidIn = '0; reqFirstIn = '0; reqLastIn = '0; reqBlockIn = '0;
    hReadyIn = 1'b0; hValidIn = 1'b0; hHashIn = '0;
    tick(); tick();
    resetN = 1'b1;
  endtask

  function automatic logic [1:0] gmask(input int g);
    return (g == 1) ? 2'b10 : 2'b01;
  endfunction

  // Reference digest the bench's hasher computes over every word of a message.
  function automatic logic [7:0][31:0] digest(input logic [31:0] w[$]);
    logic [7:0][31:0] d;
    for (int j = 0; j < 8; j++) begin
      d[j] = 32'h9E3779B9 * 32'(j + 1);
      foreach (w[k]) d[j] = ((d[j] ^ w[k]) * 32'h01000193) + 32'(j);
    end
    return d;
  endfunction

  task automatic test_reset();
    logic [15:0][31:0] b0, b1;
    logic [7:0][31:0]  h;
    rand_block(b0); rand_block(b1); rand_hash(h);
    resetN = 1'b0; reqValidIn = 2'b11; reqFirstIn = 2'b11; reqLastIn = 2'b10;
    reqBlockIn[0] = b0; reqBlockIn[1] = b1; hReadyIn = 1'b1; hValidIn = 1'b1; hHashIn = h;
    tick(); tick(); settle();
    checks++; if (reqReadyOut !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", reqReadyOut); end
    checks++; if (respValidOut !== 2'b00) begin failures++; $display("FAIL reset_resp_valid got=%b exp=00", respValidOut); end
    checks++; if (respErrOut !== 2'b00) begin failures++; $display("FAIL reset_resp_err got=%b exp=00", respErrOut); end
    checks++; if (respHashOut !== '0) begin failures++; $display("FAIL reset_resp_hash got=%h exp=0", respHashOut); end
    checks++; if ({hValidOut, hFirstOut, hLastOut} !== 3'b000) begin failures++; $display("FAIL reset_h_flags got=%b exp=000", {hValidOut, hFirstOut, hLastOut}); end
    checks++; if (hBlockOut !== '0) begin failures++; $display("FAIL reset_h_block got=%h exp=0", hBlockOut); end
    checks++; if ({t8_hValidOut, t8_reqReadyOut} !== 3'b000) begin failures++; $display("FAIL reset_t8_out got=%b exp=000", {t8_hValidOut, t8_reqReadyOut}); end
    do_reset();
  endtask

  task automatic test_single();
    logic [15:0][31:0] b0, b1;
    logic [7:0][31:0]  h;
    do_reset();
    rand_block(b0); rand_block(b1);
    for (int k = 0; k < 8; k++) h[k] = 32'h11111111;
    reqValidIn = 2'b01; reqFirstIn = 2'b01; reqLastIn = 2'b00; reqBlockIn[0] = b0; hReadyIn = 1'b1;
    settle();
    checks++; if ({hValidOut, reqReadyOut} !== 3'b000) begin failures++; $display("FAIL single_idle got=%b exp=000", {hValidOut, reqReadyOut}); end
    tick(); settle();
    checks++; if ({hValidOut, hFirstOut, hLastOut, reqReadyOut} !== 5'b11001) begin failures++; $display("FAIL single_beat0_flags got=%b exp=11001", {hValidOut, hFirstOut, hLastOut, reqReadyOut}); end
    checks++; if (hBlockOut !== b0) begin failures++; $display("FAIL single_beat0_block got=%h exp=%h", hBlockOut, b0); end
    tick();
    reqFirstIn = 2'b00; reqLastIn = 2'b01; reqBlockIn[0] = b1;
    settle();
    checks++; if ({hValidOut, hFirstOut, hLastOut} !== 3'b101) begin failures++; $display("FAIL single_beat1_flags got=%b exp=101", {hValidOut, hFirstOut, hLastOut}); end
    checks++; if (hBlockOut !== b1) begin failures++; $display("FAIL single_beat1_block got=%h exp=%h", hBlockOut, b1); end
    tick();
    reqValidIn = 2'b00; reqLastIn = 2'b00;
    for (int k = 0; k < 10; k++) begin
      hValidIn = (k == 9); hHashIn = (k == 9) ? h : '0;
      settle();
      checks++; if ({respValidOut, hValidOut} !== 3'b000) begin failures++; $display("FAIL single_wait k=%0d got=%b exp=000", k, {respValidOut, hValidOut}); end
      tick();
    end
    hValidIn = 1'b0; hHashIn = '0;
    settle();
    checks++; if (respValidOut !== 2'b01) begin failures++; $display("FAIL single_resp_valid got=%b exp=01", respValidOut); end
    checks++; if (respHashOut !== h) begin failures++; $display("FAIL single_resp_hash got=%h exp=%h", respHashOut, h); end
    tick(); settle();
    checks++; if (respValidOut !== 2'b00) begin failures++; $display("FAIL single_resp_once got=%b exp=00", respValidOut); end
    checks++; if (respHashOut !== h) begin failures++; $display("FAIL single_hash_hold got=%h exp=%h", respHashOut, h); end
  endtask

  task automatic test_contention();
    logic [15:0][31:0] b0, b1, b2, b3;
    logic [7:0][31:0]  h0, h1;
    do_reset();
    rand_block(b0); rand_block(b1); rand_block(b2); rand_block(b3); rand_hash(h0); rand_hash(h1);
    reqValidIn = 2'b11; reqFirstIn = 2'b11; reqLastIn = 2'b11; reqBlockIn[0] = b0; reqBlockIn[1] = b1; hReadyIn = 1'b1;
    settle(); tick(); settle();
    checks++; if (reqReadyOut !== 2'b01) begin failures++; $display("FAIL cont_first_grant got=%b exp=01", reqReadyOut); end
    checks++; if (hBlockOut !== b0) begin failures++; $display("FAIL cont_first_block got=%h exp=%h", hBlockOut, b0); end
    tick();
    reqValidIn = 2'b10; hValidIn = 1'b1; hHashIn = h0;
    settle();
    checks++; if ({hValidOut, reqReadyOut} !== 3'b000) begin failures++; $display("FAIL cont_wait got=%b exp=000", {hValidOut, reqReadyOut}); end
    tick();
    hValidIn = 1'b0;
    settle();
    checks++; if (respValidOut !== 2'b01 || respHashOut !== h0) begin failures++; $display("FAIL cont_resp0 got=%b/%h exp=01/%h", respValidOut, respHashOut, h0); end
    tick(); settle();
    checks++; if ({hValidOut, reqReadyOut} !== 3'b000) begin failures++; $display("FAIL cont_idle_gap got=%b exp=000", {hValidOut, reqReadyOut}); end
    tick(); settle();
    checks++; if (reqReadyOut !== 2'b10 || hBlockOut !== b1) begin failures++; $display("FAIL cont_second_grant got=%b/%h exp=10/%h", reqReadyOut, hBlockOut, b1); end
    tick();
    reqValidIn = 2'b01; reqBlockIn[0] = b2; hValidIn = 1'b1; hHashIn = h1;
    settle(); tick();
    hValidIn = 1'b0; reqValidIn = 2'b11; reqBlockIn[1] = b3;
    settle();
    checks++; if (respValidOut !== 2'b10 || respHashOut !== h1) begin failures++; $display("FAIL cont_resp1 got=%b/%h exp=10/%h", respValidOut, respHashOut, h1); end
    tick(); settle(); tick(); settle();
    checks++; if (reqReadyOut !== 2'b01 || hBlockOut !== b2) begin failures++; $display("FAIL cont_second_tie got=%b/%h exp=01/%h", reqReadyOut, hBlockOut, b2); end
    do_reset();
  endtask

  task automatic test_backpressure();
    logic [15:0][31:0] blk [3];
    logic [15:0][31:0] other;
    bit pat [8] = '{1, 0, 1, 0, 1, 1, 1, 1};
    int ptr = 0;
    int beats = 0;
    do_reset();
    for (int i = 0; i < 3; i++) rand_block(blk[i]);
    rand_block(other);
    reqValidIn = 2'b11; reqFirstIn = 2'b11; reqLastIn = 2'b10; reqBlockIn[0] = blk[0]; reqBlockIn[1] = other; hReadyIn = 1'b1;
    settle(); tick();
    for (int c = 0; c < 8; c++) begin
      hReadyIn = pat[c];
      reqValidIn[0] = (ptr < 3); reqFirstIn[0] = (ptr == 0); reqLastIn[0] = (ptr == 2);
      reqBlockIn[0] = (ptr < 3) ? blk[ptr] : '0;
      settle();
      if (ptr < 3) begin
        checks++; if (reqReadyOut !== {1'b0, hReadyIn}) begin failures++; $display("FAIL bp_ready c=%0d got=%b exp=%b", c, reqReadyOut, {1'b0, hReadyIn}); end
        checks++; if (hValidOut !== 1'b1 || hBlockOut !== blk[ptr]) begin failures++; $display("FAIL bp_block c=%0d got=%b/%h exp=1/%h", c, hValidOut, hBlockOut, blk[ptr]); end
      end else begin
        checks++; if ({hValidOut, reqReadyOut} !== 3'b000) begin failures++; $display("FAIL bp_after c=%0d got=%b exp=000", c, {hValidOut, reqReadyOut}); end
      end
      if (hValidOut && hReadyIn) begin beats++; ptr++; end
      tick();
    end
    checks++; if (beats !== 3) begin failures++; $display("FAIL bp_beat_count got=%0d exp=3", beats); end
    do_reset();
  endtask

  task automatic test_timeout();
    logic [15:0][31:0] b0, b1;
    logic [7:0][31:0]  h;
    do_reset();
    rand_block(b0); rand_block(b1); rand_hash(h);
    reqValidIn = 2'b01; reqFirstIn = 2'b01; reqLastIn = 2'b01; reqBlockIn[0] = b0; hReadyIn = 1'b1;
    settle(); tick(); settle();
    checks++; if (t8_reqReadyOut !== 2'b01) begin failures++; $display("FAIL to_grant got=%b exp=01", t8_reqReadyOut); end
    tick();
    reqValidIn = 2'b00;
    for (int k = 0; k < 12; k++) begin
      hValidIn = (k == 9); hHashIn = h;
      settle();
      checks++; if (t8_respErrOut !== ((k == 8) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL to_err k=%0d got=%b exp=%b", k, t8_respErrOut, (k == 8) ? 2'b01 : 2'b00); end
      checks++; if (t8_respValidOut !== 2'b00) begin failures++; $display("FAIL to_no_resp k=%0d got=%b exp=00", k, t8_respValidOut); end
      tick();
    end
    hValidIn = 1'b0;
    reqValidIn = 2'b11; reqFirstIn = 2'b11; reqLastIn = 2'b11; reqBlockIn[1] = b1;
    settle(); tick(); settle();
    checks++; if (t8_reqReadyOut !== 2'b10 || t8_hBlockOut !== b1) begin failures++; $display("FAIL to_rr_after_abort got=%b/%h exp=10/%h", t8_reqReadyOut, t8_hBlockOut, b1); end
    do_reset();
  endtask

  task automatic test_simultaneous();
    logic [15:0][31:0] b1;
    logic [7:0][31:0]  h;
    do_reset();
    rand_block(b1); rand_hash(h);
    reqValidIn = 2'b10; reqFirstIn = 2'b10; reqLastIn = 2'b10; reqBlockIn[1] = b1; hReadyIn = 1'b1;
    settle(); tick(); settle(); tick();
    reqValidIn = 2'b00;
    for (int k = 0; k < 9; k++) begin
      hValidIn = (k == 8); hHashIn = h;
      settle();
      checks++; if (t8_respErrOut !== 2'b00) begin failures++; $display("FAIL sim_err k=%0d got=%b exp=00", k, t8_respErrOut); end
      tick();
    end
    hValidIn = 1'b0;
    settle();
    checks++; if (t8_respValidOut !== 2'b10 || t8_respHashOut !== h) begin failures++; $display("FAIL sim_resp got=%b/%h exp=10/%h", t8_respValidOut, t8_respHashOut, h); end
    tick(); settle();
    checks++; if ({t8_respValidOut, t8_respErrOut} !== 4'b0000) begin failures++; $display("FAIL sim_after got=%b exp=0000", {t8_respValidOut, t8_respErrOut}); end
    do_reset();
  endtask

  task automatic test_reset_mid();
    logic [15:0][31:0] b0, c0, c1, d;
    logic [7:0][31:0]  h;
    do_reset();
    rand_block(b0); rand_block(c0); rand_block(c1); rand_block(d); rand_hash(h);
    reqValidIn = 2'b01; reqFirstIn = 2'b01; reqLastIn = 2'b01; reqBlockIn[0] = b0; hReadyIn = 1'b1;
    settle(); tick(); settle(); tick();
    reqValidIn = 2'b00; hValidIn = 1'b1; hHashIn = h;
    settle(); tick();
    hValidIn = 1'b0;
    settle(); tick();
    reqValidIn = 2'b01; reqFirstIn = 2'b01; reqLastIn = 2'b00; reqBlockIn[0] = c0;
    settle(); tick(); settle(); tick();
    reqValidIn = 2'b11; reqFirstIn = 2'b10; reqLastIn = 2'b11; reqBlockIn[0] = c1; reqBlockIn[1] = d;
    resetN = 1'b0;
    settle(); tick(); settle();
    checks++; if ({reqReadyOut, respValidOut, respErrOut, hValidOut, hFirstOut, hLastOut} !== 9'b0) begin failures++; $display("FAIL mid_reset_out got=%b exp=0", {reqReadyOut, respValidOut, respErrOut, hValidOut, hFirstOut, hLastOut}); end
    checks++; if (respHashOut !== '0 || hBlockOut !== '0) begin failures++; $display("FAIL mid_reset_data got=%h/%h exp=0/0", respHashOut, hBlockOut); end
    resetN = 1'b1; reqFirstIn = 2'b11; reqBlockIn[0] = c0;
    settle();
    checks++; if ({reqReadyOut, respValidOut, respErrOut} !== 6'b0) begin failures++; $display("FAIL mid_reset_idle got=%b exp=0", {reqReadyOut, respValidOut, respErrOut}); end
    tick(); settle();
    checks++; if (reqReadyOut !== 2'b01 || hBlockOut !== c0) begin failures++; $display("FAIL mid_reset_tie got=%b/%h exp=01/%h", reqReadyOut, hBlockOut, c0); end
    do_reset();
  endtask

  logic [15:0][31:0] rb_blk   [2][32];
  bit                rb_first [2][32];
  bit                rb_last  [2][32];
  logic [7:0][31:0]  rm_hash  [2][8];

  // Message-level model: each requester streams queued messages; grants alternate while both are pending.
  task automatic test_random();
    int nb[2], nm[2], ptr[2], ridx[2];
    int owner, last_owner, cd, cyc;
    bit in_msg, job, exp_resp, started, e0, e1;
    logic [1:0] exp_mask;
    logic [31:0] wq[$];
    logic [31:0] hq[$];
    logic [15:0][31:0] blk;
    logic [7:0][31:0] junk;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      nb[i] = 0; nm[i] = $urandom_range(2, 6); ptr[i] = 0; ridx[i] = 0;
      for (int m = 0; m < nm[i]; m++) begin
        int len = $urandom_range(1, 3);
        wq.delete();
        for (int b = 0; b < len; b++) begin
          rand_block(blk);
          rb_blk[i][nb[i]] = blk; rb_first[i][nb[i]] = (b == 0); rb_last[i][nb[i]] = (b == len - 1);
          for (int k = 0; k < 16; k++) wq.push_back(blk[k]);
          nb[i]++;
        end
        rm_hash[i][m] = digest(wq);
      end
    end
    owner = 0; last_owner = 1; in_msg = 0; job = 0; cd = 0; exp_resp = 0; cyc = 0;
    hq.delete();
    while (!(ptr[0] == nb[0] && ptr[1] == nb[1] && !in_msg && !job && !exp_resp) && cyc < 4000) begin
      for (int i = 0; i < 2; i++) begin
        reqValidIn[i] = (ptr[i] < nb[i]);
        reqFirstIn[i] = (ptr[i] < nb[i]) ? rb_first[i][ptr[i]] : 1'b0;
        reqLastIn[i]  = (ptr[i] < nb[i]) ? rb_last[i][ptr[i]] : 1'b0;
        reqBlockIn[i] = (ptr[i] < nb[i]) ? rb_blk[i][ptr[i]] : '0;
      end
      hReadyIn = ($urandom_range(0, 3) != 0);
      hValidIn = 1'b0; hHashIn = '0; started = 0;
      if (job) begin
        if (cd == 0) begin hValidIn = 1'b1; hHashIn = digest(hq); end
      end else if ($urandom_range(0, 7) == 0) begin
        rand_hash(junk); hValidIn = 1'b1; hHashIn = junk;
      end
      settle();
      exp_mask = exp_resp ? gmask(owner) : 2'b00;
      checks++; if (respValidOut !== exp_mask) begin failures++; $display("FAIL rnd_resp_valid cyc=%0d got=%b exp=%b", cyc, respValidOut, exp_mask); end
      if (exp_resp) begin
        checks++; if (respHashOut !== rm_hash[owner][ridx[owner]]) begin failures++; $display("FAIL rnd_resp_hash cyc=%0d got=%h exp=%h", cyc, respHashOut, rm_hash[owner][ridx[owner]]); end
        ridx[owner]++; exp_resp = 0;
      end
      checks++; if (respErrOut !== 2'b00) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=00", cyc, respErrOut); end
      if (hValidOut && hReadyIn) begin
        if (!in_msg) begin
          e0 = (ptr[0] < nb[0]); e1 = (ptr[1] < nb[1]);
          owner = (e0 && e1) ? 1 - last_owner : (e0 ? 0 : 1);
          last_owner = owner; in_msg = 1;
        end
        checks++; if (reqReadyOut !== gmask(owner)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, reqReadyOut, gmask(owner)); end
        checks++;
        if ({hBlockOut, hFirstOut, hLastOut} !== {rb_blk[owner][ptr[owner]], rb_first[owner][ptr[owner]], rb_last[owner][ptr[owner]]}) begin
          failures++; $display("FAIL rnd_beat cyc=%0d got=%h/%b%b exp=%h/%b%b", cyc, hBlockOut, hFirstOut, hLastOut,
                               rb_blk[owner][ptr[owner]], rb_first[owner][ptr[owner]], rb_last[owner][ptr[owner]]);
        end
        for (int k = 0; k < 16; k++) hq.push_back(hBlockOut[k]);
        if (hLastOut) begin in_msg = 0; job = 1; cd = $urandom_range(0, 5); started = 1; end
      end
      for (int i = 0; i < 2; i++) if (reqValidIn[i] && reqReadyOut[i]) ptr[i]++;
      if (job && !started) begin
        if (hValidIn) begin job = 0; exp_resp = 1; hq.delete(); end
        else cd--;
      end
      tick();
      cyc++;
    end
    checks++; if (cyc >= 4000) begin failures++; $display("FAIL rnd_budget got=%0d exp<4000", cyc); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (ridx[i] !== nm[i]) begin failures++; $display("FAIL rnd_msg_count req=%0d got=%0d exp=%0d", i, ridx[i], nm[i]); end
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    for (int r = 0; r < 4; r++) test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
